multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Multi-cycle MIPS controller: a Moore/Mealy state machine that sequences each instruction over FETCH/DECODE/EXEC/MEM/WB states. It generates per-cycle datapath enables and mux selects, waits on a memory ready handshake, and stalls for a parametrised-latency multiply/divide unit. It sits beside the multi-cycle datapath. Its inputs are Op/Func from the instruction register and Zero from the ALU. It supports addu, subu, ori, lui, lw, sw, beq, jal, jr, mult, multu, div, divu, mfhi and mflo.

## Interface
- MULT_CYCLES, 5, MDU busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, MDU busy cycles for div/divu (≥1)
- CNT_W, 4, MDU counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Op  in  6  IR[31:26]
- Func  in  6  IR[5:0]
- Zero  in  1  ALU equality flag
- mem_ready  in  1  memory completes the current MemRead/MemWrite this cycle
- PCWrite, IRWrite, RegWrite, MemRead, MemWrite  out  1 each  datapath enables
- RegDstSel, ALUSrcSel, toRegSel, NPCOp, EXTOp  out  3 each  mux/extend selects
- ALUOp  out  4  ALU function
- MDUStart  out  1  one-cycle start pulse to MDU
- MDUOp  out  2  0 mult, 1 multu, 2 div, 3 divu
- Busy  out  1  high while in MDU state
- Illegal  out  1  one-cycle pulse in DECODE for an unrecognised Op/Func
- State  out  3  current state, for debug

## Operation
- Encodings:
  - RegDstSel: 0 rt, 1 rd, 2 $31.
  - ALUSrcSel: 0 RD2, 1 EXT.
  - toRegSel: 0 ALU, 1 Mem, 2 EXT, 3 PC4, 4 HI, 5 LO.
  - NPCOp: 0 PC4, 1 beq, 2 jal, 3 jr.
  - ALUOp: 1 or, 2 add, 3 sub, 0 otherwise.
  - EXTOp: 0 zero-extend, 1 sign-extend, 2 load-high.
- Enables default to 0 in every state. Selects default to 0 unless listed.
- FETCH:
  - MemRead=1 until mem_ready.
  - On mem_ready: IRWrite=1, PCWrite=1, NPCOp=0, then go to DECODE.
  - Outputs do not depend on Op/Func, which are stale here.
- DECODE:
  - jal: PCWrite=1, NPCOp=2, RegWrite=1, RegDstSel=2, toRegSel=3, then FETCH.
  - jr: PCWrite=1, NPCOp=3, then FETCH.
  - Illegal: Illegal=1, then FETCH (executes as nop).
  - All other instructions: go to EXEC.
- EXEC:
  - ALUOp/ALUSrcSel/EXTOp are driven per instruction.
  - addu/subu/ori/lui/mfhi/mflo: go to WB.
  - lw/sw: ALUOp=2, EXTOp=1, go to MEM.
  - beq: ALUOp=3, PCWrite=Zero, NPCOp=1, then FETCH.
  - mult*/div*: MDUStart=1, MDUOp set, counter loaded with MULT_CYCLES or DIV_CYCLES, go to MDU.
- MEM:
  - lw holds MemRead=1; sw holds MemWrite=1; address selects held stable.
  - Stay in MEM until mem_ready, then sw goes to FETCH and lw goes to WB.
- WB:
  - RegWrite=1 for exactly one cycle, with the instruction's RegDstSel/toRegSel.
  - lui: toRegSel=2. mfhi: toRegSel=4. mflo: toRegSel=5. Then FETCH.
- MDU:
  - Busy=1; the counter decrements each cycle.
  - When counter==1, go to FETCH.
  - Total MDU-state cycles equal the parameter exactly. The counter never wraps.

## Timing
- While reset is low: State=FETCH, counter=0, and every output is forced to 0, including MemRead.
- First MemRead is asserted in the first cycle after reset deasserts.
- Reset asserted mid-instruction (any state, including MEM or MDU) aborts immediately. Outputs drop to 0 asynchronously.
- mem_ready is sampled only in FETCH and MEM and is ignored elsewhere. mem_ready already high on entry completes in that same cycle.
- Cycle counts with zero-wait memory:
  - jal/jr: 2. beq: 3. R-type/ori/lui: 4. sw: 4. lw: 5.
  - mult/div: 3 + MULT_CYCLES or 3 + DIV_CYCLES.
- Each memory wait cycle adds one cycle to the instruction.
- A new instruction cannot be fetched while Busy, so mfhi/mflo can never overlap an MDU operation.

## Structure
- Package mc_pkg holds:
  - opcode and funct constants;
  - the state encoding (FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, MDU 5);
  - the select encodings listed above.
- Sub-module mc_decode: purely combinational Op/Func to one-hot instruction wires plus illegal flag.
- The top module holds the state register, the MDU counter and output logic.

## Test plan
- Reset low then high, mem_ready=1, Op=ORI:
  - All outputs are 0 during reset.
  - The cycle after release has MemRead=1 and State=0.
  - Instruction completes as FETCH→DECODE→EXEC→WB, with RegWrite=1 only in WB, RegDstSel=0, toRegSel=0, ALUOp=1, EXTOp=0.
- lw with mem_ready held low for 3 cycles in MEM:
  - MemRead stays 1 for 4 MEM cycles.
  - WB follows with toRegSel=1.
  - Total 8 cycles.
- beq with Zero=1 versus Zero=0: PCWrite=1/0 in EXEC with NPCOp=1, then FETCH.
- div with DIV_CYCLES=10:
  - MDUStart pulses once with MDUOp=2.
  - Busy is high for exactly 10 cycles.
  - A following mflo writes with toRegSel=5.
- Op=6'b111111:
  - Illegal pulses for 1 cycle in DECODE.
  - No RegWrite/MemWrite/PCWrite is asserted beyond the fetch increment.
  - Next FETCH follows.
- Reset driven low during the MDU state at counter=4:
  - Outputs drop to 0 immediately and Busy=0.
  - After release, normal fetch resumes.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, functs,
// FSM state encoding, datapath select encodings and the control bundle.
package mc_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // Functs (IR[5:0]) for R-type
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDU    = 3'd5
    } state_e;

    // RegDstSel
    localparam logic [2:0] RD_RT = 3'd0;
    localparam logic [2:0] RD_RD = 3'd1;
    localparam logic [2:0] RD_RA = 3'd2;
    // ALUSrcSel
    localparam logic [2:0] ASRC_RD2 = 3'd0;
    localparam logic [2:0] ASRC_EXT = 3'd1;
    // toRegSel
    localparam logic [2:0] TOREG_ALU = 3'd0;
    localparam logic [2:0] TOREG_MEM = 3'd1;
    localparam logic [2:0] TOREG_EXT = 3'd2;
    localparam logic [2:0] TOREG_PC4 = 3'd3;
    localparam logic [2:0] TOREG_HI  = 3'd4;
    localparam logic [2:0] TOREG_LO  = 3'd5;
    // NPCOp
    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_BEQ = 3'd1;
    localparam logic [2:0] NPC_JAL = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;
    // ALUOp
    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    // EXTOp
    localparam logic [2:0] EXT_ZERO = 3'd0;
    localparam logic [2:0] EXT_SIGN = 3'd1;
    localparam logic [2:0] EXT_HIGH = 3'd2;
    // MDUOp
    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    // One-hot instruction class from the decoder
    typedef struct packed {
        logic addu, subu, ori, lui, lw, sw, beq, jal, jr;
        logic mult, multu, div, divu, mfhi, mflo;
    } inst_t;

    // Everything the controller drives toward the datapath
    typedef struct packed {
        logic       pc_write, ir_write, reg_write, mem_read, mem_write;
        logic [2:0] reg_dst, alu_src, to_reg, npc_op, ext_op;
        logic [3:0] alu_op;
        logic       mdu_start;
        logic [1:0] mdu_op;
        logic       busy, illegal;
    } ctrl_t;

    // MDU operation code for a decoded mult/div instruction
    function automatic logic [1:0] mdu_op_of(input inst_t i);
        logic [1:0] r;
        r = MDU_MULT;
        if (i.multu) r = MDU_MULTU;
        if (i.div)   r = MDU_DIV;
        if (i.divu)  r = MDU_DIVU;
        return r;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: Op/Func to one-hot instruction class,
// with an illegal flag for anything outside the supported set.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    output inst_t      inst,
    output logic       illegal
);

    logic rtype;

    // Match opcode, and funct only for R-type
    always_comb begin
        inst       = '0;
        rtype      = (Op == OP_RTYPE);
        inst.addu  = rtype && (Func == FN_ADDU);
        inst.subu  = rtype && (Func == FN_SUBU);
        inst.jr    = rtype && (Func == FN_JR);
        inst.mult  = rtype && (Func == FN_MULT);
        inst.multu = rtype && (Func == FN_MULTU);
        inst.div   = rtype && (Func == FN_DIV);
        inst.divu  = rtype && (Func == FN_DIVU);
        inst.mfhi  = rtype && (Func == FN_MFHI);
        inst.mflo  = rtype && (Func == FN_MFLO);
        inst.ori   = (Op == OP_ORI);
        inst.lui   = (Op == OP_LUI);
        inst.lw    = (Op == OP_LW);
        inst.sw    = (Op == OP_SW);
        inst.beq   = (Op == OP_BEQ);
        inst.jal   = (Op == OP_JAL);
    end

    assign illegal = ~|inst;

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS controller. Holds the state register and MDU stall
// counter; datapath controls are decoded from state plus instruction.
// Controls are combinational because FETCH/MEM must react to mem_ready and
// beq to Zero in the same cycle; all of them are forced low while reset
// is asserted.
module multi_cycle_control
    import mc_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [2:0] RegDstSel,
    output logic [2:0] ALUSrcSel,
    output logic [2:0] toRegSel,
    output logic [2:0] NPCOp,
    output logic [2:0] EXTOp,
    output logic [3:0] ALUOp,
    output logic       MDUStart,
    output logic [1:0] MDUOp,
    output logic       Busy,
    output logic       Illegal,
    output logic [2:0] State
);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    inst_t            inst;
    logic             ill;
    logic             is_mdu, is_mem;
    logic [CNT_W-1:0] mdu_len;

    logic [3:0]       alu_op_i;
    logic [2:0]       alu_src_i, ext_op_i, reg_dst_i, to_reg_i;
    ctrl_t            ctrl, ctrl_o;

    mc_decode u_dec (
        .Op      (Op),
        .Func    (Func),
        .inst    (inst),
        .illegal (ill)
    );

    assign is_mdu  = inst.mult | inst.multu | inst.div | inst.divu;
    assign is_mem  = inst.lw | inst.sw;
    assign mdu_len = (inst.div | inst.divu) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // Sequencing: state register and MDU stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: state <= (inst.jal || inst.jr || ill) ? S_FETCH : S_EXEC;
                S_EXEC: begin
                    if (is_mem)         state <= S_MEM;
                    else if (inst.beq)  state <= S_FETCH;
                    else if (is_mdu) begin
                        state <= S_MDU;
                        cnt   <= mdu_len;
                    end else            state <= S_WB;
                end
                S_MEM:    if (mem_ready) state <= inst.sw ? S_FETCH : S_WB;
                S_WB:     state <= S_FETCH;
                S_MDU: begin
                    // Exit on the last counted cycle so the counter stops at 0
                    if (cnt <= CNT_W'(1)) begin
                        state <= S_FETCH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Per-instruction selects, held from EXEC through MEM/WB for stability
    always_comb begin
        alu_op_i  = ALU_NONE;
        alu_src_i = ASRC_RD2;
        ext_op_i  = EXT_ZERO;
        reg_dst_i = RD_RT;
        to_reg_i  = TOREG_ALU;
        if (inst.addu)            alu_op_i = ALU_ADD;
        if (inst.subu | inst.beq) alu_op_i = ALU_SUB;
        if (inst.ori) begin
            alu_op_i  = ALU_OR;
            alu_src_i = ASRC_EXT;
        end
        if (is_mem) begin
            alu_op_i  = ALU_ADD;
            alu_src_i = ASRC_EXT;
            ext_op_i  = EXT_SIGN;
        end
        if (inst.lui) begin
            ext_op_i = EXT_HIGH;
            to_reg_i = TOREG_EXT;
        end
        if (inst.lw)   to_reg_i = TOREG_MEM;
        if (inst.mfhi) to_reg_i = TOREG_HI;
        if (inst.mflo) to_reg_i = TOREG_LO;
        if (inst.addu | inst.subu | inst.mfhi | inst.mflo) reg_dst_i = RD_RD;
    end

    // Per-state control decode; every enable defaults low
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    ctrl.npc_op   = NPC_PC4;
                end
            end
            S_DECODE: begin
                if (inst.jal) begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.npc_op    = NPC_JAL;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_RA;
                    ctrl.to_reg    = TOREG_PC4;
                end else if (inst.jr) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.npc_op   = NPC_JR;
                end else if (ill) begin
                    ctrl.illegal = 1'b1;
                end
            end
            S_EXEC: begin
                ctrl.alu_op  = alu_op_i;
                ctrl.alu_src = alu_src_i;
                ctrl.ext_op  = ext_op_i;
                if (inst.beq) begin
                    ctrl.pc_write = Zero;
                    ctrl.npc_op   = NPC_BEQ;
                end
                if (is_mdu) begin
                    ctrl.mdu_start = 1'b1;
                    ctrl.mdu_op    = mdu_op_of(inst);
                end
            end
            S_MEM: begin
                ctrl.alu_op    = alu_op_i;
                ctrl.alu_src   = alu_src_i;
                ctrl.ext_op    = ext_op_i;
                ctrl.mem_read  = inst.lw;
                ctrl.mem_write = inst.sw;
            end
            S_WB: begin
                ctrl.alu_op    = alu_op_i;
                ctrl.alu_src   = alu_src_i;
                ctrl.ext_op    = ext_op_i;
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = reg_dst_i;
                ctrl.to_reg    = to_reg_i;
            end
            S_MDU: ctrl.busy = 1'b1;
            default: ctrl = '0;
        endcase
    end

    // Reset forces every control low immediately, even mid-instruction
    assign ctrl_o = reset ? ctrl : '0;

    assign PCWrite   = ctrl_o.pc_write;
    assign IRWrite   = ctrl_o.ir_write;
    assign RegWrite  = ctrl_o.reg_write;
    assign MemRead   = ctrl_o.mem_read;
    assign MemWrite  = ctrl_o.mem_write;
    assign RegDstSel = ctrl_o.reg_dst;
    assign ALUSrcSel = ctrl_o.alu_src;
    assign toRegSel  = ctrl_o.to_reg;
    assign NPCOp     = ctrl_o.npc_op;
    assign EXTOp     = ctrl_o.ext_op;
    assign ALUOp     = ctrl_o.alu_op;
    assign MDUStart  = ctrl_o.mdu_start;
    assign MDUOp     = ctrl_o.mdu_op;
    assign Busy      = ctrl_o.busy;
    assign Illegal   = ctrl_o.illegal;
    assign State     = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: a table of instructions with expected
// per-instruction summaries, queued as a scoreboard when issued and
// compared when the controller returns to FETCH; plus reset corner cases.
module tb_multi_cycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op, Func;
    logic       Zero, mem_ready;
    logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite;
    logic [2:0] RegDstSel, ALUSrcSel, toRegSel, NPCOp, EXTOp;
    logic [3:0] ALUOp;
    logic       MDUStart;
    logic [1:0] MDUOp;
    logic       Busy, Illegal;
    logic [2:0] State;

    int total = 0;
    int bad   = 0;

    multi_cycle_control #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Func(Func), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegDstSel(RegDstSel), .ALUSrcSel(ALUSrcSel), .toRegSel(toRegSel),
        .NPCOp(NPCOp), .EXTOp(EXTOp), .ALUOp(ALUOp), .MDUStart(MDUStart),
        .MDUOp(MDUOp), .Busy(Busy), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    wire [31:0] all_out = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
                           RegDstSel, ALUSrcSel, toRegSel, NPCOp, EXTOp,
                           ALUOp, MDUStart, MDUOp, Busy, Illegal};

    // Per-instruction summary: cycles, RegWrite info, EXEC selects, counts
    typedef struct {
        int cyc, rw, dst, toreg, alu, src, ext, enpc;
        int pcw, npc, mr, mw, st, mop, busy, ill;
    } obs_t;

    typedef struct {
        string      name;
        logic [5:0] op, func;
        logic       zero;
        int         mem_wait;
        obs_t       exp;
    } vec_t;

    vec_t vecs[$];
    obs_t sb_q[$];

    function automatic obs_t ev(int cyc, int rw, int dst, int toreg, int alu, int src,
                                int ext, int enpc, int pcw, int npc, int mr, int mw,
                                int st, int mop, int busy, int ill);
        obs_t o;
        o.cyc = cyc; o.rw = rw; o.dst = dst; o.toreg = toreg; o.alu = alu; o.src = src;
        o.ext = ext; o.enpc = enpc; o.pcw = pcw; o.npc = npc; o.mr = mr; o.mw = mw;
        o.st = st; o.mop = mop; o.busy = busy; o.ill = ill;
        return o;
    endfunction

    function automatic vec_t mkv(string n, logic [5:0] op, logic [5:0] fn, logic z,
                                 int mwait, obs_t e);
        vec_t v;
        v.name = n; v.op = op; v.func = fn; v.zero = z; v.mem_wait = mwait; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one instruction; called just after a posedge with the DUT in FETCH
    task automatic run(input vec_t v);
        obs_t o = '{default: 0};
        obs_t e;
        int   mw = v.mem_wait;
        Op = v.op; Func = v.func; Zero = v.zero;
        sb_q.push_back(v.exp);
        do begin
            if (State == 3'd3 && mw > 0) begin
                mem_ready = 1'b0;
                mw--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            o.cyc++;
            if (RegWrite) begin o.rw++; o.dst = RegDstSel; o.toreg = toRegSel; end
            if (State == 3'd2) begin
                o.alu = ALUOp; o.src = ALUSrcSel; o.ext = EXTOp; o.enpc = NPCOp;
            end
            if (PCWrite) begin o.pcw++; o.npc = NPCOp; end
            o.mr   += int'(MemRead);
            o.mw   += int'(MemWrite);
            if (MDUStart) begin o.st++; o.mop = MDUOp; end
            o.busy += int'(Busy);
            o.ill  += int'(Illegal);
            @(posedge clk); #1;
        end while (State != 3'd0 && o.cyc < 64);
        if (sb_q.size() == 0) begin
            chk({v.name, ".scoreboard_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk({v.name, ".cycles"},    o.cyc,   e.cyc);
            chk({v.name, ".regwrites"}, o.rw,    e.rw);
            chk({v.name, ".regdst"},    o.dst,   e.dst);
            chk({v.name, ".toreg"},     o.toreg, e.toreg);
            chk({v.name, ".exec_alu"},  o.alu,   e.alu);
            chk({v.name, ".exec_src"},  o.src,   e.src);
            chk({v.name, ".exec_ext"},  o.ext,   e.ext);
            chk({v.name, ".exec_npc"},  o.enpc,  e.enpc);
            chk({v.name, ".pcwrites"},  o.pcw,   e.pcw);
            chk({v.name, ".last_npc"},  o.npc,   e.npc);
            chk({v.name, ".memread"},   o.mr,    e.mr);
            chk({v.name, ".memwrite"},  o.mw,    e.mw);
            chk({v.name, ".mdustart"},  o.st,    e.st);
            chk({v.name, ".mduop"},     o.mop,   e.mop);
            chk({v.name, ".busy"},      o.busy,  e.busy);
            chk({v.name, ".illegal"},   o.ill,   e.ill);
        end
    endtask

    // Hold FETCH (mem_ready low) after reset release and check first MemRead
    task automatic release_reset(input string tag);
        @(posedge clk); #1;
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".memread_after_release"}, int'(MemRead), 1);
        chk({tag, ".state_after_release"},   int'(State),   0);
        @(posedge clk); #1;
    endtask

    initial begin
        int   wait_cnt;
        obs_t e_ori;
        e_ori = ev(4,1,0,0, 1,1,0,0, 1,0,1,0, 0,0,0,0);
        vecs.push_back(mkv("ori",    6'h0d, 6'h00, 1'b0, 0, e_ori));
        vecs.push_back(mkv("addu",   6'h00, 6'h21, 1'b0, 0, ev(4,1,1,0, 2,0,0,0, 1,0,1,0, 0,0,0,0)));
        vecs.push_back(mkv("subu",   6'h00, 6'h23, 1'b0, 0, ev(4,1,1,0, 3,0,0,0, 1,0,1,0, 0,0,0,0)));
        vecs.push_back(mkv("lui",    6'h0f, 6'h00, 1'b0, 0, ev(4,1,0,2, 0,0,2,0, 1,0,1,0, 0,0,0,0)));
        vecs.push_back(mkv("lw_w0",  6'h23, 6'h00, 1'b0, 0, ev(5,1,0,1, 2,1,1,0, 1,0,2,0, 0,0,0,0)));
        vecs.push_back(mkv("lw_w3",  6'h23, 6'h00, 1'b0, 3, ev(8,1,0,1, 2,1,1,0, 1,0,5,0, 0,0,0,0)));
        vecs.push_back(mkv("sw_w0",  6'h2b, 6'h00, 1'b0, 0, ev(4,0,0,0, 2,1,1,0, 1,0,1,1, 0,0,0,0)));
        vecs.push_back(mkv("sw_w2",  6'h2b, 6'h00, 1'b0, 2, ev(6,0,0,0, 2,1,1,0, 1,0,1,3, 0,0,0,0)));
        vecs.push_back(mkv("beq_z1", 6'h04, 6'h00, 1'b1, 0, ev(3,0,0,0, 3,0,0,1, 2,1,1,0, 0,0,0,0)));
        vecs.push_back(mkv("beq_z0", 6'h04, 6'h00, 1'b0, 0, ev(3,0,0,0, 3,0,0,1, 1,0,1,0, 0,0,0,0)));
        vecs.push_back(mkv("jal",    6'h03, 6'h00, 1'b0, 0, ev(2,1,2,3, 0,0,0,0, 2,2,1,0, 0,0,0,0)));
        vecs.push_back(mkv("jr",     6'h00, 6'h08, 1'b0, 0, ev(2,0,0,0, 0,0,0,0, 2,3,1,0, 0,0,0,0)));
        vecs.push_back(mkv("mult",   6'h00, 6'h18, 1'b0, 0, ev(8,0,0,0, 0,0,0,0, 1,0,1,0, 1,0,5,0)));
        vecs.push_back(mkv("multu",  6'h00, 6'h19, 1'b0, 0, ev(8,0,0,0, 0,0,0,0, 1,0,1,0, 1,1,5,0)));
        vecs.push_back(mkv("div",    6'h00, 6'h1a, 1'b0, 0, ev(13,0,0,0, 0,0,0,0, 1,0,1,0, 1,2,10,0)));
        vecs.push_back(mkv("mflo",   6'h00, 6'h12, 1'b0, 0, ev(4,1,1,5, 0,0,0,0, 1,0,1,0, 0,0,0,0)));
        vecs.push_back(mkv("divu",   6'h00, 6'h1b, 1'b0, 0, ev(13,0,0,0, 0,0,0,0, 1,0,1,0, 1,3,10,0)));
        vecs.push_back(mkv("mfhi",   6'h00, 6'h10, 1'b0, 0, ev(4,1,1,4, 0,0,0,0, 1,0,1,0, 0,0,0,0)));
        vecs.push_back(mkv("ill_op", 6'h3f, 6'h00, 1'b0, 0, ev(2,0,0,0, 0,0,0,0, 1,0,1,0, 0,0,0,1)));
        vecs.push_back(mkv("ill_fn", 6'h00, 6'h3f, 1'b0, 0, ev(2,0,0,0, 0,0,0,0, 1,0,1,0, 0,0,0,1)));

        // Reset held low with ORI presented and memory ready
        reset = 1'b0; mem_ready = 1'b1; Op = 6'h0d; Func = 6'h00; Zero = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.outputs_zero", int'(all_out), 0);
        chk("reset.state",        int'(State),   0);
        release_reset("por");

        foreach (vecs[i]) run(vecs[i]);

        // Reset arriving in the MDU state when the counter reads 4
        Op = 6'h00; Func = 6'h1a; mem_ready = 1'b1;
        wait_cnt = 0;
        while (!Busy && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk("mdurst.busy_reached", int'(Busy), 1);
        repeat (6) @(posedge clk);
        #1;
        chk("mdurst.busy_before", int'(Busy), 1);
        chk("mdurst.state_before", int'(State), 5);
        #2 reset = 1'b0;
        #1;
        chk("mdurst.outputs_zero", int'(all_out), 0);
        chk("mdurst.busy",         int'(Busy),    0);
        chk("mdurst.state",        int'(State),   0);
        repeat (2) @(posedge clk);
        release_reset("mdurst");
        run(vecs[0]);

        if (sb_q.size() != 0) chk("scoreboard.leftover", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
